lsu_mem_adapter: RTL and testbench

- Load/store formatting stage between the pipeline memory stage and the word-addressed data memory port (valid/ready request, one-cycle read response, 4-bit byte write mask, no response on writes).
- Converts byte-addressed, sized load/store operations into aligned word requests with byte masks and replicated store data.
- Aligns and sign/zero-extends load responses and returns them tagged with the destination register.
- Supports one outstanding operation.

---
 rtl/lsu_mem_adapter_if.sv | 50 +++++
 rtl/lsu_mem_adapter.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_adapter_if.sv
// Interface bundling the pipeline load/store port, the load-return port and the
// word-addressed data memory port of lsu_mem_adapter.
interface lsu_mem_adapter_if #(
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned WORD_ADDR_BITS = ADDR_BITS - 2
);
    logic                      ls_valid;
    logic                      ls_ready;
    logic [ADDR_BITS-1:0]      ls_addr;
    logic [DATA_BITS-1:0]      ls_wdata;
    logic                      ls_store;
    logic [1:0]                ls_size;
    logic                      ls_unsigned;
    logic [4:0]                ls_rd;

    logic                      ld_valid;
    logic [DATA_BITS-1:0]      ld_data;
    logic [4:0]                ld_rd;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [WORD_ADDR_BITS-1:0] mem_req_addr;
    logic [DATA_BITS-1:0]      mem_req_data;
    logic [3:0]                mem_req_write;
    logic                      mem_resp_valid;
    logic [DATA_BITS-1:0]      mem_resp_data;

    logic                      misalign;

    // Adapter side.
    modport master (
        input  ls_valid, ls_addr, ls_wdata, ls_store, ls_size, ls_unsigned, ls_rd,
        output ls_ready,
        output ld_valid, ld_data, ld_rd,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output misalign
    );

    // Pipeline and memory side.
    modport slave (
        output ls_valid, ls_addr, ls_wdata, ls_store, ls_size, ls_unsigned, ls_rd,
        input  ls_ready,
        input  ld_valid, ld_data, ld_rd,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  misalign
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Load/store formatting stage: sized byte-addressed ops to aligned word requests, one outstanding.
// Optional MISALIGN_TRAP_EN: misaligned half/word ops are flagged on misalign instead of issued.
module lsu_mem_adapter #(
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned WORD_ADDR_BITS = ADDR_BITS - 2
) (
    input logic               clk,
    input logic               reset,
    lsu_mem_adapter_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] TRAP = 2'd3;
`endif

    logic [1:0]                state_q, state_d;
    logic [WORD_ADDR_BITS-1:0] addr_q;
    logic [1:0]                off_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic [4:0]                rd_q;
    logic [DATA_BITS-1:0]      wdata_q;
    logic [3:0]                wmask_q;
    logic                      ld_valid_q;
    logic [DATA_BITS-1:0]      ld_data_q;
    logic [4:0]                ld_rd_q;

    logic [1:0]           off;
    logic                 accept;
    logic                 mis;
    logic [DATA_BITS-1:0] fmt_data;
    logic [3:0]           fmt_mask;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [DATA_BITS-1:0] ld_word;

    assign off    = bus.ls_addr[1:0];
    assign accept = (state_q == IDLE) && bus.ls_valid;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    assign mis = ((bus.ls_size == 2'b01) && off[0]) || (bus.ls_size[1] && (off != 2'b00));
    assign bus.misalign = misalign_q;
`else
    assign mis          = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    always_comb begin
        fmt_data = bus.ls_wdata;
        fmt_mask = 4'b1111;
        case (bus.ls_size)
            2'b00: begin
                fmt_data = {4{bus.ls_wdata[7:0]}};
                fmt_mask = 4'b0001 << off;
            end
            2'b01: begin
                fmt_data = {2{bus.ls_wdata[15:0]}};
                fmt_mask = 4'b0011 << {off[1], 1'b0};
            end
            default: ;
        endcase
        if (!bus.ls_store) fmt_mask = 4'b0000;
    end

    assign byte_sel = bus.mem_resp_data[8*off_q +: 8];
    assign half_sel = bus.mem_resp_data[16*off_q[1] +: 16];

    always_comb begin
        ld_word = bus.mem_resp_data;
        case (size_q)
            2'b00:   ld_word = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ld_word = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    // A zero write mask marks a load, so the request phase needs no separate store flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.ls_valid) begin
`ifdef MISALIGN_TRAP_EN
                    state_d = mis ? TRAP : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ:     if (bus.mem_req_ready) state_d = (wmask_q == 4'b0000) ? WAIT : IDLE;
            WAIT:    if (bus.mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            ld_rd_q    <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ld_valid_q <= 1'b0;
            if (accept) begin
                addr_q  <= bus.ls_addr[ADDR_BITS-1:2];
                off_q   <= off;
                size_q  <= bus.ls_size;
                uns_q   <= bus.ls_unsigned;
                rd_q    <= bus.ls_rd;
                wdata_q <= fmt_data;
                wmask_q <= fmt_mask;
            end
            if ((state_q == WAIT) && bus.mem_resp_valid) begin
                ld_valid_q <= 1'b1;
                ld_data_q  <= ld_word;
                ld_rd_q    <= rd_q;
            end
`ifdef MISALIGN_TRAP_EN
            misalign_q <= accept && mis;
            if (accept && mis) ld_rd_q <= bus.ls_rd;
`endif
        end
    end

    assign bus.ls_ready      = (state_q == IDLE) && reset;
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = wdata_q;
    assign bus.mem_req_write = wmask_q;
    assign bus.ld_valid      = ld_valid_q;
    assign bus.ld_data       = ld_data_q;
    assign bus.ld_rd         = ld_rd_q;

    logic unused_mis;
    assign unused_mis = mis;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed self-checking bench for lsu_mem_adapter; honours MISALIGN_TRAP_EN when defined.
module tb_lsu_mem_adapter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    lsu_mem_adapter_if bus ();

    lsu_mem_adapter dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] addr, input logic [31:0] wdata, input logic store,
                            input logic [1:0] size, input logic uns, input logic [4:0] rd);
        bus.ls_valid    = 1'b1;
        bus.ls_addr     = addr;
        bus.ls_wdata    = wdata;
        bus.ls_store    = store;
        bus.ls_size     = size;
        bus.ls_unsigned = uns;
        bus.ls_rd       = rd;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic [31:0] exp_waddr,
                            input logic [31:0] exp_data, input logic [3:0] exp_mask);
        check_val({tag, "_rdy0"}, 32'(bus.ls_ready), 32'd1);
        drive_op(addr, wdata, 1'b1, size, 1'b0, 5'd0);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.ls_valid = 1'b0;
        check_val({tag, "_reqv"}, 32'(bus.mem_req_valid), 32'd1);
        check_val({tag, "_addr"}, 32'(bus.mem_req_addr), exp_waddr);
        check_val({tag, "_data"}, bus.mem_req_data, exp_data);
        check_val({tag, "_mask"}, 32'(bus.mem_req_write), 32'(exp_mask));
        check_val({tag, "_rdy1"}, 32'(bus.ls_ready), 32'd0);
        tick;
        check_val({tag, "_rdy2"}, 32'(bus.ls_ready), 32'd1);
        check_val({tag, "_nold"}, 32'(bus.ld_valid), 32'd0);
        check_val({tag, "_idle"}, 32'(bus.mem_req_valid), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [31:0] resp,
                           input logic [31:0] exp_waddr, input logic [31:0] exp_data);
        check_val({tag, "_rdy0"}, 32'(bus.ls_ready), 32'd1);
        drive_op(addr, 32'h0, 1'b0, size, uns, rd);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.ls_valid = 1'b0;
        check_val({tag, "_reqv"}, 32'(bus.mem_req_valid), 32'd1);
        check_val({tag, "_addr"}, 32'(bus.mem_req_addr), exp_waddr);
        check_val({tag, "_mask"}, 32'(bus.mem_req_write), 32'd0);
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = resp;
        check_val({tag, "_wait"}, 32'(bus.ld_valid), 32'd0);
        check_val({tag, "_rdyw"}, 32'(bus.ls_ready), 32'd0);
        tick;
        bus.mem_resp_valid = 1'b0;
        check_val({tag, "_ldv"}, 32'(bus.ld_valid), 32'd1);
        check_val({tag, "_ldd"}, bus.ld_data, exp_data);
        check_val({tag, "_ldrd"}, 32'(bus.ld_rd), 32'(rd));
        tick;
        check_val({tag, "_pulse"}, 32'(bus.ld_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ls_valid       = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wdata       = '0;
        bus.ls_store       = 1'b0;
        bus.ls_size        = 2'b00;
        bus.ls_unsigned    = 1'b0;
        bus.ls_rd          = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        repeat (2) tick;
        check_val("rst_rdy", 32'(bus.ls_ready), 32'd0);
        check_val("rst_reqv", 32'(bus.mem_req_valid), 32'd0);
        check_val("rst_ldv", 32'(bus.ld_valid), 32'd0);
        check_val("rst_mis", 32'(bus.misalign), 32'd0);
        #2 reset = 1'b1;
        tick;
        check_val("post_rst_rdy", 32'(bus.ls_ready), 32'd1);

        // SB to top byte lane
        do_store("sb", 32'h1003, 32'h0000_00AB, 2'b00, 32'h400, 32'hABAB_ABAB, 4'b1000);
        // SH upper half
        do_store("sh", 32'h0002, 32'h1234_5678, 2'b01, 32'h0, 32'h5678_5678, 4'b1100);

        do_load("lh", 32'h2002, 2'b01, 1'b0, 5'd7, 32'h8001_1234, 32'h800, 32'hFFFF_8001);
        do_load("lhu", 32'h2000, 2'b01, 1'b1, 5'd9, 32'h8001_9234, 32'h800, 32'h0000_9234);
        do_load("lbu", 32'h3001, 2'b00, 1'b1, 5'd4, 32'h0000_F000, 32'hC00, 32'h0000_00F0);
        do_load("lb", 32'h3001, 2'b00, 1'b0, 5'd5, 32'h0000_F000, 32'hC00, 32'hFFFF_FFF0);

        // SW with memory back-pressure for 3 cycles
        drive_op(32'h10, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 5'd0);
        bus.mem_req_ready = 1'b0;
        tick;
        bus.ls_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("sw_bp_reqv", 32'(bus.mem_req_valid), 32'd1);
            check_val("sw_bp_addr", 32'(bus.mem_req_addr), 32'h4);
            check_val("sw_bp_data", bus.mem_req_data, 32'hDEAD_BEEF);
            check_val("sw_bp_mask", 32'(bus.mem_req_write), 32'hF);
            check_val("sw_bp_rdy", 32'(bus.ls_ready), 32'd0);
            tick;
        end
        bus.mem_req_ready = 1'b1;
        check_val("sw_last_reqv", 32'(bus.mem_req_valid), 32'd1);
        tick;
        check_val("sw_done_rdy", 32'(bus.ls_ready), 32'd1);
        check_val("sw_done_reqv", 32'(bus.mem_req_valid), 32'd0);

        // Misaligned LW
`ifdef MISALIGN_TRAP_EN
        drive_op(32'h1002, 32'h0, 1'b0, 2'b10, 1'b0, 5'd11);
        tick;
        bus.ls_valid = 1'b0;
        check_val("mis_pulse", 32'(bus.misalign), 32'd1);
        check_val("mis_rd", 32'(bus.ld_rd), 32'd11);
        check_val("mis_noreq", 32'(bus.mem_req_valid), 32'd0);
        check_val("mis_nold", 32'(bus.ld_valid), 32'd0);
        check_val("mis_rdy", 32'(bus.ls_ready), 32'd0);
        tick;
        check_val("mis_clear", 32'(bus.misalign), 32'd0);
        check_val("mis_idle", 32'(bus.ls_ready), 32'd1);
        check_val("mis_noreq2", 32'(bus.mem_req_valid), 32'd0);
        check_val("mis_nold2", 32'(bus.ld_valid), 32'd0);
`else
        do_load("lw_mis", 32'h1002, 2'b10, 1'b0, 5'd11, 32'h1122_3344, 32'h400, 32'h1122_3344);
        check_val("lw_mis_flag", 32'(bus.misalign), 32'd0);
`endif

        // Reset while WAITing on a load
        drive_op(32'h44, 32'h0, 1'b0, 2'b10, 1'b0, 5'd3);
        tick;
        bus.ls_valid = 1'b0;
        tick;
        #2 reset = 1'b0;
        #1;
        check_val("mrst_rdy", 32'(bus.ls_ready), 32'd0);
        check_val("mrst_reqv", 32'(bus.mem_req_valid), 32'd0);
        check_val("mrst_addr", 32'(bus.mem_req_addr), 32'd0);
        check_val("mrst_data", bus.mem_req_data, 32'd0);
        check_val("mrst_mask", 32'(bus.mem_req_write), 32'd0);
        check_val("mrst_ldv", 32'(bus.ld_valid), 32'd0);
        check_val("mrst_ldd", bus.ld_data, 32'd0);
        check_val("mrst_ldrd", 32'(bus.ld_rd), 32'd0);
        check_val("mrst_mis", 32'(bus.misalign), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_FFFF;
        tick;
        bus.mem_resp_valid = 1'b0;
        check_val("stray_nold", 32'(bus.ld_valid), 32'd0);
        check_val("stray_rdy", 32'(bus.ls_ready), 32'd1);
        do_load("lw_new", 32'h40, 2'b10, 1'b0, 5'd12, 32'hCAFE_F00D, 32'h10, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
